// File: rtl/ysyx_22050612_mem_responder.sv
// Data-memory responder: serves one load/store at a time from a 64-bit word array.
// Latency: response valid LATENCY cycles after the request handshake.
// Backpressure: response held stable until rsp_ready; no new request accepted meanwhile.
module ysyx_22050612_mem_responder #(
  parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        hold_wen;
  logic [63:0] hold_addr;
  logic [63:0] hold_wdata;
  logic [7:0]  hold_wmask;

  logic [63:0] mem [DEPTH];

  // With LATENCY=1 the access happens on the accept edge itself, before the
  // holding registers are loaded, so the live request fields are used then.
  logic        cur_wen;
  logic [63:0] cur_addr;
  logic [63:0] cur_wdata;
  logic [7:0]  cur_wmask;
  logic [63:0] off;
  logic        in_range;
  logic [DEPTH_LOG2-1:0] idx;
  logic        accept;
  logic        enter_resp;

  assign req_ready  = (state == IDLE) && rst;
  assign accept     = req_valid && req_ready;

  assign cur_wen    = (state == IDLE) ? req_wen   : hold_wen;
  assign cur_addr   = (state == IDLE) ? req_addr  : hold_addr;
  assign cur_wdata  = (state == IDLE) ? req_wdata : hold_wdata;
  assign cur_wmask  = (state == IDLE) ? req_wmask : hold_wmask;

  // Offset wraps modulo 2^64, so addresses below the base land far out of range.
  assign off        = cur_addr - ADDR_BASE;
  assign in_range   = off < (64'd8 << DEPTH_LOG2);
  assign idx        = off[DEPTH_LOG2+2:3];

  assign enter_resp = rst && ((accept && (LATENCY == 1)) ||
                              ((state == BUSY) && (cnt == 4'd1)));

  // Byte-masked array write, committed only on the edge that enters RESP.
  always_ff @(posedge clk) begin
    if (enter_resp && cur_wen && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (cur_wmask[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end

  // Control FSM with registered response outputs and request holding registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        hold_wen   <= req_wen;
        hold_addr  <= req_addr;
        hold_wdata <= req_wdata;
        hold_wmask <= req_wmask;
      end
      if (enter_resp) begin
        state     <= RESP;
        cnt       <= 4'd0;
        rsp_valid <= 1'b1;
        rsp_err   <= !in_range;
        rsp_rdata <= (in_range && !cur_wen) ? mem[idx] : 64'd0;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state <= BUSY;
              cnt   <= 4'(LATENCY - 1);
            end
          end
          BUSY: cnt <= cnt - 4'd1;
          RESP: begin
            if (rsp_ready) begin
              state     <= IDLE;
              rsp_valid <= 1'b0;
              rsp_rdata <= 64'd0;
              rsp_err   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_mem_responder.sv
// Bench for the data-memory responder: four instances at latencies 2, 1, 15 and 4.
// Byte-level reference memory per instance; directed cases followed by random traffic.
// Response backpressure is applied with random stall lengths.
module tb_ysyx_22050612_mem_responder;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [NI-1:0] req_valid = '0;
  logic [NI-1:0] req_ready;
  logic [NI-1:0] req_wen = '0;
  logic [63:0] req_addr  [NI];
  logic [63:0] req_wdata [NI];
  logic [7:0]  req_wmask [NI];
  logic [NI-1:0] rsp_valid;
  logic [NI-1:0] rsp_ready = '0;
  logic [63:0] rsp_rdata [NI];
  logic [NI-1:0] rsp_err;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] mdl [int];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ysyx_22050612_mem_responder #(
      .ADDR_BASE (BASE),
      .DEPTH_LOG2(12),
      .LATENCY   ((g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 15 : 4)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[g]),
      .req_ready(req_ready[g]),
      .req_wen  (req_wen[g]),
      .req_addr (req_addr[g]),
      .req_wdata(req_wdata[g]),
      .req_wmask(req_wmask[g]),
      .rsp_valid(rsp_valid[g]),
      .rsp_ready(rsp_ready[g]),
      .rsp_rdata(rsp_rdata[g]),
      .rsp_err  (rsp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    case (k)
      0: return 2;
      1: return 1;
      2: return 15;
      default: return 4;
    endcase
  endfunction

  // Array holds 4096 words of 8 bytes starting at BASE.
  function automatic bit in_rng(input logic [63:0] a);
    logic [63:0] o;
    o = a - BASE;
    return o < 64'd32768;
  endfunction

  function automatic int key(input int k, input logic [63:0] a);
    logic [63:0] o;
    o = (a - BASE) / 64'd8;
    return k * 4096 + int'(o);
  endfunction

  // One full transaction on instance k, with stall cycles of response backpressure.
  task automatic xact(input int k, input bit wen, input logic [63:0] addr,
                      input logic [63:0] wdata, input logic [7:0] wmask,
                      input int stall, input string tag, output logic [63:0] rd);
    int cyc;
    bit known;
    logic [63:0] er, v0;
    logic ee, v1;
    ee = !in_rng(addr);
    er = 64'd0;
    known = 1'b1;
    if (!ee) begin
      if (wen) begin
        logic [63:0] nw;
        nw = mdl.exists(key(k, addr)) ? mdl[key(k, addr)] : 64'd0;
        for (int i = 0; i < 8; i++) if (wmask[i]) nw[8*i +: 8] = wdata[8*i +: 8];
        if (mdl.exists(key(k, addr)) || wmask == 8'hFF) mdl[key(k, addr)] = nw;
      end else begin
        known = mdl.exists(key(k, addr));
        if (known) er = mdl[key(k, addr)];
      end
    end
    @(negedge clk);
    req_valid[k] = 1'b1; req_wen[k] = wen; req_addr[k] = addr;
    req_wdata[k] = wdata; req_wmask[k] = wmask;
    cyc = 0;
    while (!req_ready[k] && cyc < 50) begin @(negedge clk); cyc++; end
    chk({tag, ".acc"}, req_ready[k], 1'b1);
    @(negedge clk);
    req_valid[k] = 1'b0; req_wen[k] = 1'($urandom);
    req_addr[k] = {$urandom, $urandom}; req_wdata[k] = {$urandom, $urandom};
    req_wmask[k] = 8'($urandom);
    cyc = 1;
    while (!rsp_valid[k] && cyc < 40) begin
      chk({tag, ".busy_rdy"}, req_ready[k], 1'b0);
      @(negedge clk); cyc++;
    end
    chk({tag, ".lat"}, 64'(cyc), 64'(lat_of(k)));
    chk({tag, ".err"}, rsp_err[k], ee);
    if (known) chk({tag, ".rdata"}, rsp_rdata[k], er);
    rd = rsp_rdata[k];
    v0 = rsp_rdata[k]; v1 = rsp_err[k];
    repeat (stall) begin
      @(negedge clk);
      chk({tag, ".st_vld"}, rsp_valid[k], 1'b1);
      chk({tag, ".st_rdata"}, rsp_rdata[k], v0);
      chk({tag, ".st_err"}, rsp_err[k], v1);
      chk({tag, ".st_rdy"}, req_ready[k], 1'b0);
    end
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
    chk({tag, ".done_vld"}, rsp_valid[k], 1'b0);
    chk({tag, ".done_rdata"}, rsp_rdata[k], 64'd0);
    chk({tag, ".done_err"}, rsp_err[k], 1'b0);
    chk({tag, ".done_rdy"}, req_ready[k], 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd;
    int cyc;
    for (int k = 0; k < NI; k++) begin
      req_addr[k] = '0; req_wdata[k] = '0; req_wmask[k] = '0;
    end

    // Reset held for three cycles.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        chk("rst.vld", rsp_valid[k], 1'b0);
        chk("rst.rdata", rsp_rdata[k], 64'd0);
        chk("rst.err", rsp_err[k], 1'b0);
        chk("rst.rdy", req_ready[k], 1'b0);
      end
    end
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) chk("rst.rel_rdy", req_ready[k], 1'b1);

    // Preload words 0..15 of every instance.
    for (int k = 0; k < NI; k++)
      for (int w = 0; w < 16; w++)
        xact(k, 1'b1, BASE + 64'(8 * w), {$urandom, $urandom}, 8'hFF, 0, "pre", rd);

    // Masked write then read.
    xact(0, 1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 0, "t2.w1", rd);
    xact(0, 1'b1, 64'h8000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, "t2.w2", rd);
    xact(0, 1'b0, 64'h8000_0013, 64'd0, 8'h00, 0, "t2.r", rd);
    chk("t2.value", rd, 64'h11223344AAAAAAAA);
    xact(0, 1'b1, 64'h8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, "t2.w0", rd);
    xact(0, 1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, "t2.r0", rd);
    chk("t2.mask0", rd, 64'h11223344AAAAAAAA);

    // Out of range.
    xact(0, 1'b0, 64'h8000_8000, 64'd0, 8'h00, 1, "t3.hi", rd);
    xact(0, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00, 0, "t3.lo", rd);
    xact(0, 1'b1, 64'h8000_8000, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 0, "t3.w", rd);
    xact(0, 1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, "t3.r0", rd);
    xact(0, 1'b0, 64'h8000_7FF8 + 64'd8, 64'd0, 8'h00, 0, "t3.edge", rd);

    // Backpressure.
    xact(0, 1'b1, BASE + 64'h40, 64'hDEADBEEF00C0FFEE, 8'hFF, 0, "t4.w", rd);
    xact(0, 1'b0, BASE + 64'h40, 64'd0, 8'h00, 5, "t4.r", rd);
    chk("t4.value", rd, 64'hDEADBEEF00C0FFEE);

    // Latency extremes with req_valid held high across the response.
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      req_valid[k] = 1'b1; req_wen[k] = 1'b0; req_addr[k] = BASE;
      chk("t5.acc", req_ready[k], 1'b1);
      @(negedge clk);
      cyc = 1;
      while (!rsp_valid[k] && cyc < 40) begin
        chk("t5.hold_rdy", req_ready[k], 1'b0);
        @(negedge clk); cyc++;
      end
      chk("t5.lat", 64'(cyc), 64'(lat_of(k)));
      chk("t5.rdata", rsp_rdata[k], mdl[key(k, BASE)]);
      chk("t5.resp_rdy", req_ready[k], 1'b0);
      req_addr[k] = BASE + 64'd8;
      rsp_ready[k] = 1'b1;
      @(negedge clk);
      rsp_ready[k] = 1'b0;
      chk("t5.after_vld", rsp_valid[k], 1'b0);
      chk("t5.after_rdy", req_ready[k], 1'b1);
      @(negedge clk);
      req_valid[k] = 1'b0;
      chk("t5.b2b_taken", req_ready[k], 1'b0);
      cyc = 1;
      while (!rsp_valid[k] && cyc < 40) begin @(negedge clk); cyc++; end
      chk("t5.b2b_lat", 64'(cyc), 64'(lat_of(k)));
      chk("t5.b2b_rdata", rsp_rdata[k], mdl[key(k, BASE + 64'd8)]);
      rsp_ready[k] = 1'b1;
      @(negedge clk);
      rsp_ready[k] = 1'b0;
      chk("t5.b2b_done", rsp_valid[k], 1'b0);
    end

    // Reset in the middle of a write at latency 4.
    xact(3, 1'b1, BASE + 64'h20, 64'h0123_4567_89AB_CDEF, 8'hFF, 0, "t6.prior", rd);
    @(negedge clk);
    req_valid[3] = 1'b1; req_wen[3] = 1'b1; req_addr[3] = BASE + 64'h20;
    req_wdata[3] = 64'h5555_5555_5555_5555; req_wmask[3] = 8'hFF;
    chk("t6.acc", req_ready[3], 1'b1);
    @(negedge clk);
    req_valid[3] = 1'b0;
    chk("t6.c1_vld", rsp_valid[3], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    chk("t6.c2_vld", rsp_valid[3], 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("t6.rst_vld", rsp_valid[3], 1'b0);
      chk("t6.rst_rdy", req_ready[3], 1'b0);
    end
    rst = 1'b1;
    repeat (6) begin
      #1;
      chk("t6.rel_vld", rsp_valid[3], 1'b0);
      chk("t6.rel_rdy", req_ready[3], 1'b1);
      @(negedge clk);
    end
    xact(3, 1'b0, BASE + 64'h20, 64'd0, 8'h00, 0, "t6.r", rd);
    chk("t6.value", rd, 64'h0123_4567_89AB_CDEF);

    // Random traffic on instances 0, 1 and 3.
    for (int n = 0; n < 120; n++) begin
      int k;
      logic [63:0] a;
      int sel;
      k = (n % 3 == 2) ? 3 : n % 3;
      sel = int'($urandom_range(0, 9));
      if (sel < 8)      a = BASE + 64'(8 * $urandom_range(0, 15)) + 64'($urandom_range(0, 7));
      else if (sel == 8) a = BASE + 64'h8000 + 64'(8 * $urandom_range(0, 1000));
      else               a = BASE - 64'(8 * $urandom_range(1, 1000));
      xact(k, 1'($urandom), a, {$urandom, $urandom}, 8'($urandom),
           int'($urandom_range(0, 3)), "rnd", rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
